ascon_input_loader: RTL and testbench
=====================================

Name: ascon_input_loader

Overview:
Upstream feeder for the Ascon encryption core. It accepts key, nonce, associated data and plaintext as parallel words through a valid/ready handshake. It serialises them MSB-first onto the core's 3-bit share inputs, supplies fresh masking randomness from an internal LFSR, pulses encryption_start, and waits for the core's ready flag before accepting the next job.

Parameters:
K, 128, key width in bits
L, 40, associated-data width in bits
Y, 40, plaintext width in bits
START_LEN, 3, number of cycles encryption_start is held high
SEED, 32'hACE1_2DB0, LFSR reset value (0 is replaced by 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
load_valid_i  in  1  parallel job valid
load_ready_o  out  1  loader can accept a job
key_i  in  K  key
nonce_i  in  128  nonce
ad_i  in  L  associated data
pt_i  in  Y  plaintext
keyxSI  out  3  key share bits to core
noncexSI  out  3  nonce share bits
associated_dataxSI  out  3  AD share bits
plain_textxSI  out  3  PT share bits
r_64xSI  out  7  randomness
r_128xSI  out  1  randomness
r_ptxSI  out  1  randomness
encryption_startxSI  out  1  start to core
encryption_readyxSO  in  1  core done flag
busy_o  out  1  job in progress
done_o  out  1  one-cycle pulse when the core reports ready

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- MAX = max(K, L, Y). Counter width is clog2(MAX).
- Reset values:
  - FSM in IDLE; load_ready_o=1.
  - busy_o=0, done_o=0, encryption_startxSI=0.
  - All xSI data/random outputs 0.
  - LFSR = SEED, or 1 if SEED=0.
- All outputs are registered except load_ready_o, which equals (state==IDLE).
- LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003). Advances every cycle when rst=0.
  - Each cycle, lfsr[16:0] is registered onto {r_128xSI, r_ptxSI, r_64xSI[6:0], keyxSI[2:1], associated_dataxSI[2:1], plain_textxSI[2:1], noncexSI[2:1]}, in that bit order, in every state.
- IDLE:
  - On load_valid_i && load_ready_o, capture all four words, clear counter i=0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Runs for MAX cycles. On each edge, bit [0] of every field is registered:
    - keyxSI[0] = key[K-1-i] if i<K, else 0
    - noncexSI[0] = nonce[127-i] if i<128, else 0
    - associated_dataxSI[0] = ad[L-1-i] if i<L, else 0
    - plain_textxSI[0] = pt[Y-1-i] if i<Y, else 0
  - Bit i is therefore visible during the (i+1)-th cycle after the capture edge.
  - After i=MAX-1, go to START. busy_o=1.
- START:
  - encryption_startxSI=1 for exactly START_LEN cycles, starting the cycle after the last data bit. Then it drops and the FSM goes to WAIT.
  - All [0] data bits are 0 from START onward.
- WAIT:
  - On encryption_readyxSO=1 (sampled), done_o=1 for one cycle, busy_o=0, go to IDLE.
  - encryption_readyxSO is ignored in IDLE, SHIFT and START.
- load_valid_i while not in IDLE is ignored (load_ready_o=0). Captured words are unaffected by input changes after capture.
- Reset mid-job (any state): next cycle is IDLE with all reset values. Any partially shifted job is discarded, and start is never asserted for it.
- Back-to-back jobs: load_ready_o=1 on the same cycle done_o=1. A new job can be captured there, and SHIFT begins the following cycle.

Test Plan:
- Defaults; key=2db083053e848cefa30007336c47a5a1, nonce=3f3607dbce3503ba84f5843d623de056, ad=4153434f4e, pt=6173636f6e → 128 shift cycles. keyxSI[0] sequence rebuilds the key MSB-first. ad/pt [0] bits are 0 for i≥40. encryption_startxSI high exactly 3 cycles, asserted 129 cycles after capture.
- Hold encryption_readyxSO=0 for 500 cycles, then pulse 1 → busy_o stays 1 throughout, done_o pulses once, load_ready_o returns to 1 the same cycle.
- Assert rst at shift index 50 → next cycle state IDLE, all xSI 0, start never rises. A new job then completes with a full 128-bit shift.
- SEED=0 → LFSR reloads 1; the 17 random outputs after reset match the golden Galois model and are never all-zero for 2^16 cycles.
- load_valid_i held high with changing data during SHIFT → no second capture. The serial stream equals the first captured words.
- Parameters K=128, L=200, Y=64 → MAX=200 shift cycles. Key bits are 0 for i≥128, pt bits are 0 for i≥64. Start is asserted after cycle 200.

Source files
------------

// File: rtl/ascon_input_loader.sv
// Serialises a parallel Ascon job MSB-first onto the core's share inputs, adds LFSR
// masking randomness, pulses encryption_start and waits for the core's ready flag.
module ascon_input_loader #(
  parameter int unsigned K         = 128,
  parameter int unsigned L         = 40,
  parameter int unsigned Y         = 40,
  parameter int unsigned START_LEN = 3,
  parameter logic [31:0] SEED      = 32'hACE1_2DB0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid_i,
  output logic         load_ready_o,
  input  logic [K-1:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic [L-1:0] ad_i,
  input  logic [Y-1:0] pt_i,
  output logic [2:0]   keyxSI,
  output logic [2:0]   noncexSI,
  output logic [2:0]   associated_dataxSI,
  output logic [2:0]   plain_textxSI,
  output logic [6:0]   r_64xSI,
  output logic         r_128xSI,
  output logic         r_ptxSI,
  output logic         encryption_startxSI,
  input  logic         encryption_readyxSO,
  output logic         busy_o,
  output logic         done_o
);

  localparam int unsigned MAX_KL    = (K > L) ? K : L;
  localparam int unsigned MAX       = (MAX_KL > Y) ? MAX_KL : Y;
  localparam int unsigned CW        = (MAX > 1) ? $clog2(MAX) : 1;
  localparam int unsigned SW        = (START_LEN > 1) ? $clog2(START_LEN) : 1;
  localparam logic [31:0] LFSR_INIT = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  // state   | meaning
  // S_IDLE  | ready for a new job
  // S_SHIFT | MAX cycles of MSB-first serial data
  // S_START | encryption_start held high for START_LEN cycles
  // S_WAIT  | waiting for the core's ready flag
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_START, S_WAIT} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [K-1:0]   r_key_sr;
  logic [127:0]   r_nonce_sr;
  logic [L-1:0]   r_ad_sr;
  logic [Y-1:0]   r_pt_sr;
  logic [CW-1:0]  r_shift_cnt;
  logic [SW-1:0]  r_start_cnt;
  logic [31:0]    r_lfsr;
  logic [31:0]    w_lfsr_nxt;
  logic           w_capture;
  logic           w_shift_tc;
  logic           w_start_tc;
  logic           w_in_shift;
  logic           w_core_done;

  assign load_ready_o = (r_state == S_IDLE);
  assign w_capture    = (r_state == S_IDLE) && load_valid_i;
  assign w_in_shift   = (r_state == S_SHIFT);
  assign w_shift_tc   = (r_shift_cnt == '0);
  assign w_start_tc   = (r_start_cnt == '0);
  assign w_core_done  = (r_state == S_WAIT) && encryption_readyxSO;
  assign w_lfsr_nxt   = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (load_valid_i)        w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_shift_tc)          w_state_nxt = S_START;
      S_START: if (w_start_tc)          w_state_nxt = S_WAIT;
      S_WAIT:  if (encryption_readyxSO) w_state_nxt = S_IDLE;
      default:                          w_state_nxt = S_IDLE;
    endcase
  end

  // Both timers count down to a terminal count of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift_cnt <= '0;
      r_start_cnt <= '0;
    end else begin
      if (w_capture)                  r_shift_cnt <= CW'(MAX - 1);
      else if (w_in_shift && !w_shift_tc) r_shift_cnt <= r_shift_cnt - CW'(1);

      if (w_in_shift && w_shift_tc)   r_start_cnt <= SW'(START_LEN - 1);
      else if ((r_state == S_START) && !w_start_tc) r_start_cnt <= r_start_cnt - SW'(1);
    end
  end

  // Left-shifting zero-filled registers give zeros once a shorter field runs out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_sr   <= '0;
      r_nonce_sr <= '0;
      r_ad_sr    <= '0;
      r_pt_sr    <= '0;
    end else if (w_capture) begin
      r_key_sr   <= key_i;
      r_nonce_sr <= nonce_i;
      r_ad_sr    <= ad_i;
      r_pt_sr    <= pt_i;
    end else if (w_in_shift) begin
      r_key_sr   <= r_key_sr << 1;
      r_nonce_sr <= r_nonce_sr << 1;
      r_ad_sr    <= r_ad_sr << 1;
      r_pt_sr    <= r_pt_sr << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= LFSR_INIT;
    else     r_lfsr <= w_lfsr_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      keyxSI              <= '0;
      noncexSI            <= '0;
      associated_dataxSI  <= '0;
      plain_textxSI       <= '0;
      r_64xSI             <= '0;
      r_128xSI            <= 1'b0;
      r_ptxSI             <= 1'b0;
      encryption_startxSI <= 1'b0;
      busy_o              <= 1'b0;
      done_o              <= 1'b0;
    end else begin
      {r_128xSI, r_ptxSI, r_64xSI, keyxSI[2:1], associated_dataxSI[2:1],
       plain_textxSI[2:1], noncexSI[2:1]} <= r_lfsr[16:0];
      keyxSI[0]             <= w_in_shift && r_key_sr[K-1];
      noncexSI[0]           <= w_in_shift && r_nonce_sr[127];
      associated_dataxSI[0] <= w_in_shift && r_ad_sr[L-1];
      plain_textxSI[0]      <= w_in_shift && r_pt_sr[Y-1];
      encryption_startxSI   <= (r_state == S_START);
      done_o                <= w_core_done;
      if (w_capture)        busy_o <= 1'b1;
      else if (w_core_done) busy_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ascon_input_loader.sv
// Scoreboard bench: two loaders (default widths, and K=128/L=200/Y=64 with SEED=0)
// share one random job stream; a negedge monitor checks streams, start, done and randomness.
module tb_ascon_input_loader;

  localparam int SLEN = 3;

  typedef struct packed {
    logic [127:0] key;
    logic [127:0] nonce;
    logic [255:0] ad;
    logic [255:0] pt;
  } job_t;

  logic         clk = 1'b0;
  logic         rst, load_valid, core_rdy;
  logic [127:0] key_in, nonce_in;
  logic [255:0] ad_in, pt_in;
  logic         ld_rdy [2];
  logic         busy [2];
  logic         done [2];
  logic         start [2];
  logic         r128 [2];
  logic         rpt [2];
  logic [2:0]   k_s [2];
  logic [2:0]   n_s [2];
  logic [2:0]   a_s [2];
  logic [2:0]   p_s [2];
  logic [6:0]   r64 [2];

  int   total = 0;
  int   bad = 0;
  job_t q0[$];
  job_t q1[$];

  always #5 clk = ~clk;

  ascon_input_loader #(.K(128), .L(40), .Y(40), .START_LEN(SLEN)) dut0 (
    .clk(clk), .rst(rst), .load_valid_i(load_valid), .load_ready_o(ld_rdy[0]),
    .key_i(key_in), .nonce_i(nonce_in), .ad_i(ad_in[39:0]), .pt_i(pt_in[39:0]),
    .keyxSI(k_s[0]), .noncexSI(n_s[0]), .associated_dataxSI(a_s[0]), .plain_textxSI(p_s[0]),
    .r_64xSI(r64[0]), .r_128xSI(r128[0]), .r_ptxSI(rpt[0]),
    .encryption_startxSI(start[0]), .encryption_readyxSO(core_rdy),
    .busy_o(busy[0]), .done_o(done[0]));

  ascon_input_loader #(.K(128), .L(200), .Y(64), .START_LEN(SLEN), .SEED(32'h0)) dut1 (
    .clk(clk), .rst(rst), .load_valid_i(load_valid), .load_ready_o(ld_rdy[1]),
    .key_i(key_in), .nonce_i(nonce_in), .ad_i(ad_in[199:0]), .pt_i(pt_in[63:0]),
    .keyxSI(k_s[1]), .noncexSI(n_s[1]), .associated_dataxSI(a_s[1]), .plain_textxSI(p_s[1]),
    .r_64xSI(r64[1]), .r_128xSI(r128[1]), .r_ptxSI(rpt[1]),
    .encryption_startxSI(start[1]), .encryption_readyxSO(core_rdy),
    .busy_o(busy[1]), .done_o(done[1]));

  // field index: 0 key, 1 nonce, 2 ad, 3 pt
  function automatic int f_len(int d, int f);
    case (f)
      0, 1:    return 128;
      2:       return (d == 0) ? 40 : 200;
      default: return (d == 0) ? 40 : 64;
    endcase
  endfunction

  function automatic int f_max(int d);
    int m = f_len(d, 0);
    if (f_len(d, 2) > m) m = f_len(d, 2);
    if (f_len(d, 3) > m) m = f_len(d, 3);
    return m;
  endfunction

  function automatic logic [31:0] f_seed(int d);
    return (d == 0) ? 32'hACE1_2DB0 : 32'h0000_0001;
  endfunction

  function automatic logic [31:0] lfsr_step(logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [255:0] f_word(job_t j, int f);
    case (f)
      0:       return {128'b0, j.key};
      1:       return {128'b0, j.nonce};
      2:       return j.ad;
      default: return j.pt;
    endcase
  endfunction

  // Expected serial stream: position i holds word bit W-1-i, zero past the field width.
  function automatic logic [255:0] exp_stream(job_t j, int d, int f);
    logic [255:0] w = f_word(j, f);
    logic [255:0] e = '0;
    int wl = f_len(d, f);
    for (int i = 0; i < f_max(d); i++)
      if (i < wl) e[i] = w[wl-1-i];
    return e;
  endfunction

  function automatic job_t rand_job();
    logic [767:0] v;
    for (int i = 0; i < 24; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int           n [2]       = '{-1, -1};
  bit           in_job [2]  = '{1'b0, 1'b0};
  bit           exp_done [2] = '{1'b0, 1'b0};
  logic [16:0]  exp_rand [2];
  logic [31:0]  mlfsr [2];
  logic [255:0] col [2][4];
  bit           rand_ok = 1'b0;

  always @(negedge clk) begin : mon
    int          mx;
    logic [16:0] rnd;
    job_t        j;
    for (int d = 0; d < 2; d++) begin
      mx  = f_max(d);
      rnd = {r128[d], rpt[d], r64[d], k_s[d][2:1], a_s[d][2:1], p_s[d][2:1], n_s[d][2:1]};
      if (rand_ok) chk($sformatf("d%0d_rand", d), 256'(rnd), 256'(exp_rand[d]));
      chk($sformatf("d%0d_done", d), 256'(done[d]), 256'(exp_done[d]));
      if (exp_done[d]) in_job[d] = 1'b0;
      chk($sformatf("d%0d_busy", d), 256'(busy[d]), 256'(in_job[d]));
      chk($sformatf("d%0d_ready", d), 256'(ld_rdy[d]), 256'(!in_job[d]));
      if (in_job[d] && n[d] >= 1 && n[d] <= mx) begin
        col[d][0][n[d]-1] = k_s[d][0];
        col[d][1][n[d]-1] = n_s[d][0];
        col[d][2][n[d]-1] = a_s[d][0];
        col[d][3][n[d]-1] = p_s[d][0];
      end else begin
        chk($sformatf("d%0d_quiet_bits", d),
            256'({k_s[d][0], n_s[d][0], a_s[d][0], p_s[d][0]}), 256'(0));
      end
      chk($sformatf("d%0d_start", d), 256'(start[d]),
          256'(in_job[d] && n[d] > mx && n[d] <= mx + SLEN));
      if (in_job[d] && n[d] == mx + SLEN) begin
        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
          chk($sformatf("d%0d_queue_depth", d), 256'(0), 256'(1));
        end else begin
          j = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("d%0d_key_stream", d),   col[d][0], exp_stream(j, d, 0));
          chk($sformatf("d%0d_nonce_stream", d), col[d][1], exp_stream(j, d, 1));
          chk($sformatf("d%0d_ad_stream", d),    col[d][2], exp_stream(j, d, 2));
          chk($sformatf("d%0d_pt_stream", d),    col[d][3], exp_stream(j, d, 3));
        end
      end
      // predictions for the coming edge
      exp_done[d] = !rst && in_job[d] && n[d] >= mx + SLEN && core_rdy;
      exp_rand[d] = rst ? 17'd0 : mlfsr[d][16:0];
      mlfsr[d]    = rst ? f_seed(d) : lfsr_step(mlfsr[d]);
      if (rst) begin
        if (in_job[d]) begin
          if (d == 0 && q0.size() > 0) void'(q0.pop_front());
          if (d == 1 && q1.size() > 0) void'(q1.pop_front());
        end
        in_job[d] = 1'b0;
        n[d]      = -1;
      end else if (in_job[d]) begin
        n[d]++;
      end else if (load_valid && ld_rdy[d]) begin
        in_job[d] = 1'b1;
        n[d]      = 0;
        for (int f = 0; f < 4; f++) col[d][f] = '0;
      end
    end
    if (rst) rand_ok = 1'b1;
  end

  // ---------------- stimulus ----------------
  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic give_up(input string what);
    total++;
    bad++;
    $display("FAIL %s got=timeout want=handshake", what);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic drive_job(input job_t j);
    key_in   = j.key;
    nonce_in = j.nonce;
    ad_in    = j.ad;
    pt_in    = j.pt;
    load_valid = 1'b1;
  endtask

  task automatic start_job(input job_t j);
    int guard = 0;
    drive_job(j);
    while (!(ld_rdy[0] && ld_rdy[1])) begin
      step_cycle();
      guard++;
      if (guard > 2000) give_up("wait_load_ready");
    end
    step_cycle();
    q0.push_back(j);
    q1.push_back(j);
    load_valid = 1'b0;
  endtask

  // First 100 cycles after capture: both loaders are still shifting.
  task automatic shift_phase(input bit noisy);
    for (int c = 0; c < 100; c++) begin
      if (noisy) begin
        drive_job(rand_job());
        core_rdy = 1'b0;
      end else begin
        core_rdy = 1'($urandom_range(0, 1));
      end
      step_cycle();
    end
    load_valid = 1'b0;
    core_rdy   = 1'b0;
  endtask

  task automatic finish_job(input int delay);
    repeat (delay) step_cycle();
    core_rdy = 1'b1;
    step_cycle();
    core_rdy = 1'b0;
  endtask

  initial begin
    job_t ja;
    job_t jb;
    rst = 1'b1; load_valid = 1'b0; core_rdy = 1'b0;
    key_in = '0; nonce_in = '0; ad_in = '0; pt_in = '0;
    repeat (3) step_cycle();
    rst = 1'b0;
    step_cycle();

    ja.key   = 128'h2db083053e848cefa30007336c47a5a1;
    ja.nonce = 128'h3f3607dbce3503ba84f5843d623de056;
    ja.ad    = 256'h4153434f4e;
    ja.pt    = 256'h6173636f6e;
    start_job(ja); shift_phase(1'b0); finish_job(120);
    repeat (3) step_cycle();

    jb = rand_job(); start_job(jb); shift_phase(1'b0); finish_job(500);
    repeat (2) step_cycle();

    jb = rand_job(); start_job(jb);
    repeat (50) step_cycle();
    rst = 1'b1;
    step_cycle();
    rst = 1'b0;
    repeat (260) step_cycle();

    jb = rand_job(); start_job(jb); shift_phase(1'b1);
    repeat (130) step_cycle();
    ja = rand_job();
    drive_job(ja);
    core_rdy = 1'b1;
    step_cycle();
    core_rdy = 1'b0;
    start_job(ja); shift_phase(1'b0); finish_job(115);

    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(0, 4)) step_cycle();
      jb = rand_job(); start_job(jb); shift_phase(1'b0);
      finish_job(110 + $urandom_range(0, 60));
    end

    repeat (5) step_cycle();
    chk("scoreboard_drained", 256'(q0.size() + q1.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
